// File: rtl/lsb_queue_param.sv
// Load/store buffer: an in-order queue of memory ops between the dispatcher and
// LSCtrl. Operand tags are snooped on CDB_N broadcast channels. The head entry is
// issued through a valid/ready handshake with a held output register.
// An explicit occupancy counter tells full from empty once the pointers wrap.
module lsb_queue_param #(
  parameter int DEPTH       = 16,
  parameter int PTR_W       = 4,
  parameter int DATA_W      = 32,
  parameter int ROB_W       = 4,
  parameter int OP_W        = 6,
  parameter int CDB_N       = 2,
  parameter int FULL_MARGIN = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    dp_valid_in,
  input  logic                    dp_is_store_in,
  input  logic [OP_W-1:0]         dp_op_in,
  input  logic [ROB_W-1:0]        dp_qj_in,
  input  logic [ROB_W-1:0]        dp_qk_in,
  input  logic [DATA_W-1:0]       dp_vj_in,
  input  logic [DATA_W-1:0]       dp_vk_in,
  input  logic [DATA_W-1:0]       dp_imm_in,
  input  logic [ROB_W-1:0]        dp_rob_id_in,
  output logic                    full_dp_out,
  output logic [PTR_W:0]          count_out,
  input  logic [ROB_W-1:0]        rob_head_id_in,
  input  logic [CDB_N-1:0]        cdb_rdy_in,
  input  logic [CDB_N*ROB_W-1:0]  cdb_rob_id_in,
  input  logic [CDB_N*DATA_W-1:0] cdb_result_in,
  input  logic                    flush_in,
  output logic                    iss_valid_out,
  input  logic                    iss_ready_in,
  output logic [OP_W-1:0]         iss_op_out,
  output logic [DATA_W-1:0]       iss_vj_out,
  output logic [DATA_W-1:0]       iss_vk_out,
  output logic [DATA_W-1:0]       iss_imm_out,
  output logic [ROB_W-1:0]        iss_rob_id_out
);

  localparam logic [PTR_W:0] DEPTH_C  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] FULL_THR = (PTR_W+1)'(DEPTH - FULL_MARGIN);

  logic              e_store [DEPTH];
  logic [OP_W-1:0]   e_op    [DEPTH];
  logic [ROB_W-1:0]  e_qj    [DEPTH];
  logic [ROB_W-1:0]  e_qk    [DEPTH];
  logic [DATA_W-1:0] e_vj    [DEPTH];
  logic [DATA_W-1:0] e_vk    [DEPTH];
  logic [DATA_W-1:0] e_imm   [DEPTH];
  logic [ROB_W-1:0]  e_rob   [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic active;
  logic do_disp;
  logic load_iss;
  logic eligible;
  logic do_iss;

  logic [DATA_W:0] dp_wake_j;
  logic [DATA_W:0] dp_wake_k;
  logic [DATA_W:0] wake_j [DEPTH];
  logic [DATA_W:0] wake_k [DEPTH];

  // Returns {hit, value}. Tag 0 never matches. Channels are scanned from the
  // highest index down, so the lowest matching channel is the one that sticks.
  function automatic logic [DATA_W:0] cdb_lookup(input logic [ROB_W-1:0] tag);
    logic [DATA_W:0] r;
    r = '0;
    if (tag != '0) begin
      for (int k = CDB_N - 1; k >= 0; k--) begin
        if (cdb_rdy_in[k] && (cdb_rob_id_in[k*ROB_W +: ROB_W] == tag)) begin
          r = {1'b1, cdb_result_in[k*DATA_W +: DATA_W]};
        end
      end
    end
    return r;
  endfunction

  assign active    = rdy_in && !flush_in;
  assign do_disp   = active && dp_valid_in && (count < DEPTH_C);
  assign load_iss  = !iss_valid_out || iss_ready_in;
  assign eligible  = (count != '0) && (e_qj[head] == '0) && (e_qk[head] == '0) &&
                     (!e_store[head] || (e_rob[head] == rob_head_id_in));
  assign do_iss    = active && load_iss && eligible;

  assign full_dp_out = (count >= FULL_THR);
  assign count_out   = count;

  assign dp_wake_j = cdb_lookup(dp_qj_in);
  assign dp_wake_k = cdb_lookup(dp_qk_in);

  // CDB match for every stored operand tag
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wake_j[i] = cdb_lookup(e_qj[i]);
      wake_k[i] = cdb_lookup(e_qk[i]);
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_disp) tail <= tail + 1'b1;
        if (do_iss)  head <= head + 1'b1;
        case ({do_disp, do_iss})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Entry storage: wakeups on stored entries, then the dispatch write at tail
  // (tail is never a live entry while a dispatch is accepted)
  always_ff @(posedge clk_in) begin
    if (!rst_in && active) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wake_j[i][DATA_W]) begin
          e_qj[i] <= '0;
          e_vj[i] <= wake_j[i][DATA_W-1:0];
        end
        if (wake_k[i][DATA_W]) begin
          e_qk[i] <= '0;
          e_vk[i] <= wake_k[i][DATA_W-1:0];
        end
      end
      if (do_disp) begin
        e_store[tail] <= dp_is_store_in;
        e_op[tail]    <= dp_op_in;
        e_imm[tail]   <= dp_imm_in;
        e_rob[tail]   <= dp_rob_id_in;
        e_qj[tail]    <= dp_wake_j[DATA_W] ? '0 : dp_qj_in;
        e_vj[tail]    <= dp_wake_j[DATA_W] ? dp_wake_j[DATA_W-1:0] : dp_vj_in;
        e_qk[tail]    <= dp_wake_k[DATA_W] ? '0 : dp_qk_in;
        e_vk[tail]    <= dp_wake_k[DATA_W] ? dp_wake_k[DATA_W-1:0] : dp_vk_in;
      end
    end
  end

  // Issue register: reloads from the head whenever it is empty or being taken
  always_ff @(posedge clk_in) begin
    if (rst_in || (rdy_in && flush_in)) begin
      iss_valid_out  <= 1'b0;
      iss_op_out     <= '0;
      iss_vj_out     <= '0;
      iss_vk_out     <= '0;
      iss_imm_out    <= '0;
      iss_rob_id_out <= '0;
    end else if (rdy_in && load_iss) begin
      iss_valid_out  <= eligible;
      iss_op_out     <= e_op[head];
      iss_vj_out     <= e_vj[head];
      iss_vk_out     <= e_vk[head];
      iss_imm_out    <= e_imm[head];
      iss_rob_id_out <= e_rob[head];
    end
  end

endmodule

// File: tb/tb_lsb_queue_param.sv
// Bench for lsb_queue_param: vector table for dispatch/CDB bypass cases, hand
// sequences for store gating, fill/wrap, flush and rdy_in freeze, with a
// scoreboard of expected issues checked at each handshake.
module tb_lsb_queue_param;
  localparam int DEPTH = 16, PTR_W = 4, DATA_W = 32, ROB_W = 4, OP_W = 6;
  localparam int CDB_N = 2, FULL_MARGIN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, rdy, dp_valid, dp_is_store, flush, iss_ready;
  logic [OP_W-1:0]   dp_op;
  logic [ROB_W-1:0]  dp_qj, dp_qk, dp_rob, rob_head;
  logic [DATA_W-1:0] dp_vj, dp_vk, dp_imm;
  logic [CDB_N-1:0]  cdb_rdy;
  logic [CDB_N*ROB_W-1:0]  cdb_rob;
  logic [CDB_N*DATA_W-1:0] cdb_res;
  logic              full_dp, iss_valid;
  logic [PTR_W:0]    count;
  logic [OP_W-1:0]   iss_op;
  logic [DATA_W-1:0] iss_vj, iss_vk, iss_imm;
  logic [ROB_W-1:0]  iss_rob;

  lsb_queue_param #(.DEPTH(DEPTH), .PTR_W(PTR_W), .DATA_W(DATA_W), .ROB_W(ROB_W),
                    .OP_W(OP_W), .CDB_N(CDB_N), .FULL_MARGIN(FULL_MARGIN)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .dp_valid_in(dp_valid), .dp_is_store_in(dp_is_store), .dp_op_in(dp_op),
    .dp_qj_in(dp_qj), .dp_qk_in(dp_qk), .dp_vj_in(dp_vj), .dp_vk_in(dp_vk),
    .dp_imm_in(dp_imm), .dp_rob_id_in(dp_rob),
    .full_dp_out(full_dp), .count_out(count), .rob_head_id_in(rob_head),
    .cdb_rdy_in(cdb_rdy), .cdb_rob_id_in(cdb_rob), .cdb_result_in(cdb_res),
    .flush_in(flush), .iss_valid_out(iss_valid), .iss_ready_in(iss_ready),
    .iss_op_out(iss_op), .iss_vj_out(iss_vj), .iss_vk_out(iss_vk),
    .iss_imm_out(iss_imm), .iss_rob_id_out(iss_rob)
  );

  typedef struct {
    logic [3:0]  rob;
    logic [31:0] vj, vk, imm;
    logic [5:0]  op;
  } exp_t;

  typedef struct {
    logic [3:0]  qj, qk;
    logic [31:0] vj, vk;
    logic [3:0]  rob;
    logic [1:0]  crdy;
    logic [3:0]  t0, t1;
    logic [31:0] r0, r1, evj, evk;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dp(input logic st, input logic [3:0] rob, input logic [3:0] qj,
                        input logic [3:0] qk, input logic [31:0] vj, input logic [31:0] vk);
    dp_valid = 1'b1; dp_is_store = st; dp_rob = rob;
    dp_qj = qj; dp_qk = qk; dp_vj = vj; dp_vk = vk;
    dp_imm = 32'h100 + 32'(rob);
    dp_op  = {2'b01, rob};
  endtask

  task automatic push(input logic [3:0] rob, input logic [31:0] vj, input logic [31:0] vk);
    exp_t e;
    e.rob = rob; e.vj = vj; e.vk = vk; e.imm = 32'h100 + 32'(rob); e.op = {2'b01, rob};
    sb.push_back(e);
  endtask

  task automatic clr_dp();
    dp_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((count != 0 || iss_valid) && n < budget) begin
      step();
      n++;
    end
    check({name, "_drained"}, {63'd0, (count == 0 && !iss_valid)}, 64'd1);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard: a handshake happens at the next edge when these hold mid-cycle
  always @(negedge clk) begin
    if (!rst && rdy && !flush && iss_valid && iss_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: issued rob %0d, required no issue", iss_rob);
      end else begin
        mon_e = sb.pop_front();
        check("iss_rob", 64'(iss_rob), 64'(mon_e.rob));
        check("iss_vj", 64'(iss_vj), 64'(mon_e.vj));
        check("iss_vk", 64'(iss_vk), 64'(mon_e.vk));
        check("iss_op_imm", {26'd0, iss_op, iss_imm}, {26'd0, mon_e.op, mon_e.imm});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b0; flush = 1'b0; iss_ready = 1'b1; rob_head = '0;
    dp_valid = 1'b0; dp_is_store = 1'b0; dp_op = '0; dp_qj = '0; dp_qk = '0;
    dp_vj = '0; dp_vk = '0; dp_imm = '0; dp_rob = '0;
    cdb_rdy = '0; cdb_rob = '0; cdb_res = '0;

    vecs[0] = '{4'd0, 4'd0, 32'h11111111, 32'h22222222, 4'd1, 2'b00, 4'd0, 4'd0,
                32'h0, 32'h0, 32'h11111111, 32'h22222222};
    vecs[1] = '{4'd7, 4'd0, 32'h0, 32'h33333333, 4'd2, 2'b10, 4'd0, 4'd7,
                32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h33333333};
    vecs[2] = '{4'd0, 4'd3, 32'h44440000, 32'h0, 4'd3, 2'b11, 4'd3, 4'd3,
                32'hAAAA0000, 32'hBBBB1111, 32'h44440000, 32'hAAAA0000};
    vecs[3] = '{4'd6, 4'd6, 32'h0, 32'h0, 4'd4, 2'b01, 4'd6, 4'd0,
                32'h12345678, 32'h0, 32'h12345678, 32'h12345678};
    vecs[4] = '{4'd0, 4'd0, 32'h55555555, 32'h66666666, 4'd5, 2'b01, 4'd0, 4'd0,
                32'h99999999, 32'h0, 32'h55555555, 32'h66666666};
    vecs[5] = '{4'd2, 4'd9, 32'h0, 32'h0, 4'd6, 2'b11, 4'd9, 4'd2,
                32'h0000900D, 32'h00002222, 32'h00002222, 32'h0000900D};
    vecs[6] = '{4'd4, 4'd0, 32'h0, 32'h77777777, 4'd7, 2'b10, 4'd4, 4'd4,
                32'hBAD00004, 32'h44444444, 32'h44444444, 32'h77777777};

    // Reset with rdy low
    repeat (3) step();
    check("rst_valid", 64'(iss_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_full", 64'(full_dp), 64'd0);
    check("rst_iss_rob", 64'(iss_rob), 64'd0);
    check("rst_iss_vj", 64'(iss_vj), 64'd0);
    rst = 1'b0; rdy = 1'b1;
    step();

    // Three back-to-back loads
    set_dp(1'b0, 4'd1, 4'd0, 4'd0, 32'hA1, 32'hB1); push(4'd1, 32'hA1, 32'hB1);
    step();
    set_dp(1'b0, 4'd2, 4'd0, 4'd0, 32'hA2, 32'hB2); push(4'd2, 32'hA2, 32'hB2);
    step();
    check("b2b_v1", 64'(iss_valid), 64'd1);
    check("b2b_rob1", 64'(iss_rob), 64'd1);
    set_dp(1'b0, 4'd3, 4'd0, 4'd0, 32'hA3, 32'hB3); push(4'd3, 32'hA3, 32'hB3);
    step();
    clr_dp();
    check("b2b_v2", 64'(iss_valid), 64'd1);
    check("b2b_rob2", 64'(iss_rob), 64'd2);
    step();
    check("b2b_v3", 64'(iss_valid), 64'd1);
    check("b2b_rob3", 64'(iss_rob), 64'd3);
    check("b2b_count0", 64'(count), 64'd0);
    step();
    check("b2b_idle", 64'(iss_valid), 64'd0);
    drain("b2b", 10);

    // Vector table: dispatch with same-cycle CDB traffic
    for (int i = 0; i < 7; i++) begin
      set_dp(1'b0, vecs[i].rob, vecs[i].qj, vecs[i].qk, vecs[i].vj, vecs[i].vk);
      cdb_rdy = vecs[i].crdy;
      cdb_rob = {vecs[i].t1, vecs[i].t0};
      cdb_res = {vecs[i].r1, vecs[i].r0};
      push(vecs[i].rob, vecs[i].evj, vecs[i].evk);
      step();
      clr_dp(); cdb_rdy = '0;
      check($sformatf("vec%0d_lat0", i), 64'(iss_valid), 64'd0);
      step();
      check($sformatf("vec%0d_lat1", i), 64'(iss_valid), 64'd1);
      drain($sformatf("vec%0d", i), 10);
    end

    // Store waits for its ROB head; the load behind it waits too
    rob_head = 4'd4;
    set_dp(1'b1, 4'd5, 4'd0, 4'd0, 32'h5005, 32'h5115); push(4'd5, 32'h5005, 32'h5115);
    step();
    set_dp(1'b0, 4'd6, 4'd0, 4'd0, 32'h6006, 32'h6116); push(4'd6, 32'h6006, 32'h6116);
    step();
    clr_dp();
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("st_block%0d", i), 64'(iss_valid), 64'd0);
    end
    check("st_block_count", 64'(count), 64'd2);
    rob_head = 4'd5;
    step();
    check("st_go_valid", 64'(iss_valid), 64'd1);
    check("st_go_rob", 64'(iss_rob), 64'd5);
    step();
    check("st_ld_valid", 64'(iss_valid), 64'd1);
    check("st_ld_rob", 64'(iss_rob), 64'd6);
    rob_head = 4'd0;
    drain("store", 10);

    // Fill to DEPTH with ready low; full threshold; hold stability; wrap
    iss_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      int exp_cnt;
      set_dp(1'b0, 4'(i), 4'd0, 4'd0, 32'h1000 + 32'(i), 32'h2000 + 32'(i));
      push(4'(i), 32'h1000 + 32'(i), 32'h2000 + 32'(i));
      step();
      exp_cnt = (i == 0) ? 1 : i;
      check($sformatf("fill_count%0d", i), 64'(count), 64'(exp_cnt));
      check($sformatf("fill_full%0d", i), 64'(full_dp), 64'(exp_cnt >= DEPTH - FULL_MARGIN));
    end
    clr_dp();
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hold_valid%0d", i), 64'(iss_valid), 64'd1);
      check($sformatf("hold_rob%0d", i), 64'(iss_rob), 64'd0);
      check($sformatf("hold_vj%0d", i), 64'(iss_vj), 64'h1000);
    end
    set_dp(1'b0, 4'hF, 4'd0, 4'd0, 32'hBAD, 32'hBAD);
    $display("note: protocol error driven on purpose: dispatch while count is DEPTH");
    step();
    clr_dp();
    check("full_drop_count", 64'(count), 64'd16);
    iss_ready = 1'b1;
    step();
    check("full_pop_count", 64'(count), 64'd15);
    set_dp(1'b0, 4'd1, 4'd0, 4'd0, 32'h1011, 32'h2011); push(4'd1, 32'h1011, 32'h2011);
    step();
    clr_dp();
    check("disp_iss_same_count", 64'(count), 64'd15);
    drain("wrap", 40);

    // Flush with a pending issue
    iss_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_dp(1'b0, 4'(8 + i), 4'd0, 4'd0, 32'h3000 + 32'(i), 32'h0);
      push(4'(8 + i), 32'h3000 + 32'(i), 32'h0);
      step();
    end
    clr_dp();
    check("pre_flush_count", 64'(count), 64'd6);
    check("pre_flush_valid", 64'(iss_valid), 64'd1);
    flush = 1'b1;
    set_dp(1'b0, 4'hE, 4'd0, 4'd0, 32'hBAD1, 32'hBAD1);
    step();
    flush = 1'b0; clr_dp();
    sb.delete();
    check("flush_valid", 64'(iss_valid), 64'd0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_iss_rob", 64'(iss_rob), 64'd0);
    iss_ready = 1'b1;
    set_dp(1'b0, 4'd9, 4'd0, 4'd0, 32'h5A5A0009, 32'h9); push(4'd9, 32'h5A5A0009, 32'h9);
    step();
    clr_dp();
    check("post_flush_count", 64'(count), 64'd1);
    step();
    check("post_flush_valid", 64'(iss_valid), 64'd1);
    check("post_flush_rob", 64'(iss_rob), 64'd9);
    drain("flush", 10);

    // rdy_in low for 4 cycles with CDB and dispatch traffic
    set_dp(1'b0, 4'd1, 4'd0, 4'd0, 32'hF1, 32'hF2); push(4'd1, 32'hF1, 32'hF2);
    step();
    set_dp(1'b0, 4'd3, 4'd5, 4'd0, 32'h0, 32'hC3); push(4'd3, 32'hCAFE0005, 32'hC3);
    step();
    clr_dp();
    check("frz_pre_valid", 64'(iss_valid), 64'd1);
    check("frz_pre_count", 64'(count), 64'd1);
    rdy = 1'b0;
    cdb_rdy = 2'b01; cdb_rob = {4'd0, 4'd5}; cdb_res = {32'h0, 32'hBADBAD05};
    set_dp(1'b0, 4'd7, 4'd0, 4'd0, 32'h77, 32'h77);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("frz_valid%0d", i), 64'(iss_valid), 64'd1);
      check($sformatf("frz_rob%0d", i), 64'(iss_rob), 64'd1);
      check($sformatf("frz_count%0d", i), 64'(count), 64'd1);
    end
    rdy = 1'b1; clr_dp(); cdb_rdy = '0;
    step();
    check("res_blocked", 64'(iss_valid), 64'd0);
    check("res_count", 64'(count), 64'd1);
    cdb_rdy = 2'b10; cdb_rob = {4'd5, 4'd0}; cdb_res = {32'hCAFE0005, 32'h0};
    step();
    cdb_rdy = '0;
    check("res_wake_lat", 64'(iss_valid), 64'd0);
    step();
    check("res_valid", 64'(iss_valid), 64'd1);
    check("res_rob", 64'(iss_rob), 64'd3);
    drain("freeze", 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
